// File: rtl/bird_sprite_plotter.sv
// Erases the 4x4 bird sprite at its previous row, then redraws it at the new row, one pixel per clock.
// Optional BIRD_SPRITE_EYE_EN paints a single eye pixel (column +2, row +1) in white during the draw.
module bird_sprite_plotter #(
  parameter logic [7:0] BIRD_X      = 8'd20,
  parameter logic [2:0] BIRD_COLOUR = 3'b110,
  parameter logic [2:0] BG_COLOUR   = 3'b000,
  parameter logic [6:0] Y_MAX       = 7'd116
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       y_valid,
  input  logic [6:0] y_in,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

`ifdef BIRD_SPRITE_EYE_EN
  localparam logic EYE_EN = 1'b1;
`else
  localparam logic EYE_EN = 1'b0;
`endif

  state_t     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [6:0] new_y_q, new_y_d;
  logic [6:0] old_y_q, old_y_d;
  logic       prev_valid_q, prev_valid_d;
  logic [7:0] vga_x_q, vga_x_d;
  logic [6:0] vga_y_q, vga_y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [6:0] y_clamped;

  function automatic logic [6:0] clamp_y(input logic [6:0] y);
    return (y > Y_MAX) ? Y_MAX : y;
  endfunction

  function automatic logic [2:0] draw_colour(input logic [3:0] pc);
    return (EYE_EN && pc == 4'd9) ? 3'b111 : BIRD_COLOUR;
  endfunction

  assign y_clamped = clamp_y(y_in);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    new_y_d      = new_y_q;
    old_y_d      = old_y_q;
    prev_valid_d = prev_valid_q;

    case (state_q)
      IDLE: begin
        if (y_valid) begin
          new_y_d = y_clamped;
          pc_d    = 4'd0;
          if (!prev_valid_q)              state_d = DRAW;
          else if (y_clamped == old_y_q)  state_d = DONE;
          else                            state_d = ERASE;
        end
      end
      ERASE: begin
        pc_d = pc_q + 4'd1;
        if (pc_q == 4'd15) state_d = DRAW;
      end
      DRAW: begin
        pc_d = pc_q + 4'd1;
        if (pc_q == 4'd15) begin
          old_y_d      = new_y_q;
          prev_valid_d = 1'b1;
          state_d      = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so the first pixel appears the cycle after the request.
    plot_d   = (state_d == ERASE) || (state_d == DRAW);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    vga_x_d  = vga_x_q;
    vga_y_d  = vga_y_q;
    colour_d = colour_q;
    if (state_d == ERASE) begin
      vga_x_d  = BIRD_X + {6'd0, pc_d[3:2]};
      vga_y_d  = old_y_q + {5'd0, pc_d[1:0]};
      colour_d = BG_COLOUR;
    end else if (state_d == DRAW) begin
      vga_x_d  = BIRD_X + {6'd0, pc_d[3:2]};
      vga_y_d  = new_y_d + {5'd0, pc_d[1:0]};
      colour_d = draw_colour(pc_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      pc_q         <= 4'd0;
      new_y_q      <= 7'd0;
      old_y_q      <= 7'd0;
      prev_valid_q <= 1'b0;
      vga_x_q      <= BIRD_X;
      vga_y_q      <= 7'd0;
      colour_q     <= BG_COLOUR;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      new_y_q      <= new_y_d;
      old_y_q      <= old_y_d;
      prev_valid_q <= prev_valid_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      colour_q     <= colour_d;
      plot_q       <= plot_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = colour_q;
  assign plot       = plot_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_bird_sprite_plotter.sv
// Scoreboard bench for bird_sprite_plotter: expected pixel writes are queued per request and popped on each plot.
module tb_bird_sprite_plotter;

  logic       clk = 1'b0;
  logic       resetn;
  logic       y_valid;
  logic [6:0] y_in;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot;
  logic       busy;
  logic       done;

`ifdef BIRD_SPRITE_EYE_EN
  localparam bit TB_EYE = 1'b1;
`else
  localparam bit TB_EYE = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  int plot_count = 0;
  int eye_count = 0;
  logic [17:0] exp_q[$];
  bit          m_prev = 1'b0;
  logic [6:0]  m_old = 7'd0;

  bird_sprite_plotter dut (
    .clk(clk), .resetn(resetn), .y_valid(y_valid), .y_in(y_in),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Pixel monitor: every plot cycle must match the next queued pixel.
  always @(negedge clk) begin
    if (plot) begin
      logic [17:0] e;
      plot_count++;
      if (vga_colour == 3'b111) eye_count++;
      total++;
      if (vga_y > 7'd119) begin
        bad++;
        $display("FAIL y_range: vga_y=%0d required <= 119", vga_y);
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_plot: got x=%0d y=%0d col=%b, none required", vga_x, vga_y, vga_colour);
      end else begin
        e = exp_q.pop_front();
        if ({vga_x, vga_y, vga_colour} !== e)
          begin
            bad++;
            $display("FAIL pixel: got x=%0d y=%0d col=%b required x=%0d y=%0d col=%b",
                     vga_x, vga_y, vga_colour, e[17:10], e[9:3], e[2:0]);
          end
      end
    end
  end

  task automatic push_sprite(input logic [6:0] y, input logic [2:0] col, input bit is_draw);
    for (int pc = 0; pc < 16; pc++) begin
      logic [3:0] p;
      logic [2:0] c;
      p = pc[3:0];
      c = (is_draw && TB_EYE && p == 4'd9) ? 3'b111 : col;
      exp_q.push_back({8'd20 + {6'd0, p[3:2]}, y + {5'd0, p[1:0]}, c});
    end
  endtask

  task automatic send_request(input logic [6:0] y);
    @(negedge clk);
    y_valid = 1'b1;
    y_in    = y;
    @(posedge clk);
    #1 y_valid = 1'b0;
  endtask

  task automatic do_update(input logic [6:0] y, input bit noisy);
    logic [6:0] yc;
    int lat, npix, seen, pc0;
    bit busy_ok;
    yc = (y > 7'd116) ? 7'd116 : y;
    if (!m_prev) begin
      lat = 17; npix = 16;
      push_sprite(yc, 3'b110, 1'b1);
    end else if (yc == m_old) begin
      lat = 1; npix = 0;
    end else begin
      lat = 33; npix = 32;
      push_sprite(m_old, 3'b000, 1'b0);
      push_sprite(yc, 3'b110, 1'b1);
    end
    m_old = yc;
    m_prev = 1'b1;
    pc0 = plot_count;
    seen = 0;
    busy_ok = 1'b1;
    send_request(y);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      y_valid = 1'b0;
      if (done) begin
        seen = k;
        if (noisy) begin
          y_valid = 1'b1;
          y_in = 7'($urandom_range(0, 127));
        end
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (noisy && (k % 3 == 0)) begin
        y_valid = 1'b1;
        y_in = 7'($urandom_range(0, 127));
      end
    end
    @(posedge clk);
    #1 y_valid = 1'b0;
    total++;
    if (seen != lat) begin
      bad++;
      $display("FAIL done_latency y=%0d: got %0d required %0d", y, seen, lat);
    end
    total++;
    if (!busy_ok) begin
      bad++;
      $display("FAIL busy_span y=%0d: busy=0 before done, required 1", y);
    end
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL after_done y=%0d: busy=%b done=%b required 0 0", y, busy, done);
    end
    total++;
    if (plot_count - pc0 != npix) begin
      bad++;
      $display("FAIL plot_count y=%0d: got %0d required %0d", y, plot_count - pc0, npix);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pixels_left y=%0d: got %0d required 0", y, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if ({vga_x, vga_y, vga_colour, plot, busy, done} !== {8'd20, 7'd0, 3'b000, 3'b000}) begin
      bad++;
      $display("FAIL %s: got x=%0d y=%0d col=%b plot=%b busy=%b done=%b required x=20 y=0 col=000 plot=0 busy=0 done=0",
               tag, vga_x, vga_y, vga_colour, plot, busy, done);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    y_valid = 1'b0;
    y_in = 7'd0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset_state");
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_first_draw();
    do_update(7'd40, 1'b0);
  endtask

  task automatic test_move();
    do_update(7'd44, 1'b0);
  endtask

  task automatic test_unchanged();
    do_update(7'd44, 1'b1);
  endtask

  task automatic test_clamp_busy_drop();
    do_update(7'd127, 1'b1);
  endtask

  task automatic test_reset_mid_erase();
    int pc0;
    push_sprite(m_old, 3'b000, 1'b0);
    pc0 = plot_count;
    send_request(7'd60);
    for (int k = 1; k <= 8; k++) @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1 check_reset_outputs("mid_erase_reset");
    exp_q.delete();
    total++;
    if (plot_count - pc0 != 8) begin
      bad++;
      $display("FAIL erase_before_reset: got %0d plots required 8", plot_count - pc0);
    end
    @(negedge clk);
    resetn = 1'b1;
    m_prev = 1'b0;
    m_old = 7'd0;
    do_update(7'd10, 1'b0);
  endtask

  task automatic test_eye();
    eye_count = 0;
    do_update(7'd40, 1'b0);
    total++;
    if (eye_count != (TB_EYE ? 1 : 0)) begin
      bad++;
      $display("FAIL eye_pixels: got %0d required %0d", eye_count, TB_EYE ? 1 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_first_draw();
    test_move();
    test_unchanged();
    test_clamp_busy_drop();
    test_reset_mid_erase();
    test_eye();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
